// File: rtl/zebu_clk_detect_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe edge detector.
package zebu_clk_detect_pkg;

    // Per-channel edge qualification mode (2 bits per channel on the mode bus).
    typedef enum logic [1:0] {
        OFF  = 2'b00,
        POS  = 2'b01,
        NEG  = 2'b10,
        BOTH = 2'b11
    } edge_mode_e;

    // Upper bound on the number of monitored channels.
    localparam int unsigned MAX_CH = 32;

    // $clog2 that never returns 0, so a single channel still gets a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zebu_clk_detect_rr_arb.sv
// Combinational round-robin search: returns the first set request strictly after
// the pointer, wrapping modulo NUM_CH. Returns 0 when nothing is requested.
module zebu_clk_detect_rr_arb
    import zebu_clk_detect_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   gnt_o
);

    // Walk ptr+1 .. ptr+NUM_CH and keep the first hit.
    always_comb begin
        logic              found;
        int unsigned       idx;
        logic [NUM_CH-1:0] rot;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        rot   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (32'(ptr_i) + i) % NUM_CH;
            rot = req_i >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                gnt_o = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/zebu_clk_detect_multi.sv
// Multi-channel edge detector with per-channel mode, saturating counters, sticky
// overflow and a round-robin event port towards transactor software.
// Optional glitch filter: define ZEBU_CLK_DETECT_GLITCH_FILTER_EN.
module zebu_clk_detect_multi
    import zebu_clk_detect_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SYNC_STAGES = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned CH_W        = clog2_min1(NUM_CH)
) (
    input  logic                    stable,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_sig,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       cnt_clr,
    output logic [NUM_CH-1:0]       posReady,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    evt_valid,
    output logic [CH_W-1:0]         evt_ch,
    input  logic                    evt_ready
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]                  hist_q, hist_d;
    logic [NUM_CH-1:0]                  raw, level;
    logic                               primed_q;
    logic [NUM_CH-1:0]                  qual, gnt_vec;
    logic [NUM_CH-1:0]                  pend_q, pend_d, rdy_q, ovf_q, ovf_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]                    ptr_q, ptr_d, arb_ch;
    logic                               grant;

    assign raw = sync_q[SYNC_STAGES-1];

`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
    logic [NUM_CH-1:0] samp_q, samp_d, agree;

    // Level only follows the sampled input once two consecutive samples agree.
    assign agree = ~(raw ^ samp_q);
    assign level = (agree & raw) | (~agree & hist_q);
`else
    assign level = raw;
`endif

    // Sampling pipeline; the prime cycle fills every stage with the current input
    // so a level already present at reset release never looks like an edge.
    always_comb begin
        sync_d = sync_q;
        hist_d = hist_q;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
        samp_d = samp_q;
`endif
        if (!primed_q) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_d[s] = in_sig;
            end
            hist_d = in_sig;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
            samp_d = in_sig;
`endif
        end else begin
            sync_d[0] = in_sig;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_d[s] = sync_q[s-1];
            end
            hist_d = level;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
            samp_d = raw;
`endif
        end
    end

    // Per-channel edge qualification against the channel's mode.
    always_comb begin
        logic pos;
        logic neg;
        qual = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pos = level[i] & ~hist_q[i];
            neg = ~level[i] & hist_q[i];
            unique case (edge_mode_e'(mode[2*i +: 2]))
                POS:     qual[i] = pos;
                NEG:     qual[i] = neg;
                BOTH:    qual[i] = pos | neg;
                default: qual[i] = 1'b0;
            endcase
        end
        if (!primed_q) begin
            qual = '0;
        end
    end

    zebu_clk_detect_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i (pend_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_ch)
    );

    assign evt_valid = |pend_q;
    assign evt_ch    = arb_ch;
    assign grant     = evt_valid & evt_ready;
    assign gnt_vec   = grant ? (NUM_CH'(1) << arb_ch) : '0;

    // Pending/overflow/counter/pointer next state; set beats grant, clear beats edge.
    always_comb begin
        pend_d = (pend_q & ~gnt_vec) | qual;
        ovf_d  = (ovf_q | (qual & pend_q & ~gnt_vec)) & ~cnt_clr;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt_clr[i]) begin
                cnt_d[i] = '0;
            end else if (qual[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        ptr_d = grant ? arb_ch : ptr_q;
    end

    // Sampling pipeline and prime flag.
    always_ff @(posedge stable) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hist_q   <= '0;
            primed_q <= 1'b0;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
            samp_q   <= '0;
`endif
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            primed_q <= 1'b1;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
            samp_q   <= samp_d;
`endif
        end
    end

    // Event bookkeeping: pulses, pending bits, overflow, counters, RR pointer.
    always_ff @(posedge stable) begin
        if (!rst_n) begin
            rdy_q  <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= CH_W'(NUM_CH - 1);
        end else begin
            rdy_q  <= qual;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
        end
    end

    assign posReady = rdy_q;
    assign edge_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_zebu_clk_detect_multi.sv
// Directed bench for zebu_clk_detect_multi (4 channels, 1 sync stage, 5-bit counters)
// with a sample-stream reference model compared every cycle.
module tb_zebu_clk_detect_multi;

    localparam int NCH = 4;
    localparam int S   = 1;
    localparam int CW  = 5;
`ifdef ZEBU_CLK_DETECT_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT  = S + 1 + FILT;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    in_sig;
    logic [2*NCH-1:0]  mode;
    logic [NCH-1:0]    cnt_clr;
    logic [NCH-1:0]    posReady;
    logic [NCH*CW-1:0] edge_cnt;
    logic [NCH-1:0]    ovf;
    logic              evt_valid;
    logic [1:0]        evt_ch;
    logic              evt_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zebu_clk_detect_multi #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (S),
        .CNT_W       (CW)
    ) dut (
        .stable    (clk),
        .rst_n     (rst_n),
        .in_sig    (in_sig),
        .mode      (mode),
        .cnt_clr   (cnt_clr),
        .posReady  (posReady),
        .edge_cnt  (edge_cnt),
        .ovf       (ovf),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int first_pending(input logic [NCH-1:0] p, input int ptr);
        for (int k = 1; k <= NCH; k++) begin
            if (p[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return 0;
    endfunction

    // Reference model: f[] is the (optionally filtered) level per sample index.
    bit             m_primed;
    logic [NCH-1:0] m_f[$];
    logic [NCH-1:0] m_x_prev;
    logic [NCH-1:0] m_pend, m_ovf, m_rdy;
    int             m_cnt[NCH];
    int             m_ptr;

    always @(posedge clk) begin
        logic [NCH-1:0]    x, f_new, f_last, fq, fh, qual, gnt, dummy;
        logic [1:0]        m;
        logic [NCH*CW-1:0] exp_cnt;
        int                g;
        x = in_sig;
        if (!rst_n) begin
            m_primed = 0;
            m_pend   = '0;
            m_ovf    = '0;
            m_rdy    = '0;
            m_ptr    = NCH - 1;
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        end else if (!m_primed) begin
            m_primed = 1;
            m_f.delete();
            for (int k = 0; k < S + 2; k++) m_f.push_back(x);
            m_x_prev = x;
            m_rdy    = '0;
            for (int c = 0; c < NCH; c++) begin
                if (cnt_clr[c]) begin
                    m_cnt[c] = 0;
                    m_ovf[c] = 1'b0;
                end
            end
        end else begin
            f_last = m_f[S + 1];
            for (int c = 0; c < NCH; c++) begin
                f_new[c] = (FILT == 0 || x[c] == m_x_prev[c]) ? x[c] : f_last[c];
            end
            m_f.push_back(f_new);
            dummy    = m_f.pop_front();
            m_x_prev = x;
            fq = m_f[1];
            fh = m_f[0];
            for (int c = 0; c < NCH; c++) begin
                m = mode[2*c +: 2];
                qual[c] = (m[0] & fq[c] & ~fh[c]) | (m[1] & ~fq[c] & fh[c]);
            end
            gnt = '0;
            if (m_pend != 0 && evt_ready) begin
                g = first_pending(m_pend, m_ptr);
                gnt[g] = 1'b1;
                m_ptr = g;
            end
            for (int c = 0; c < NCH; c++) begin
                if (cnt_clr[c]) begin
                    m_cnt[c] = 0;
                    m_ovf[c] = 1'b0;
                end else begin
                    if (qual[c] && m_cnt[c] < CMAX) m_cnt[c]++;
                    if (qual[c] && m_pend[c] && !gnt[c]) m_ovf[c] = 1'b1;
                end
            end
            m_pend = (m_pend & ~gnt) | qual;
            m_rdy  = qual;
        end
        #1;
        for (int c = 0; c < NCH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
        chk("posReady", 32'(posReady), 32'(m_rdy));
        chk("edge_cnt", 32'(edge_cnt), 32'(exp_cnt));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
        chk("evt_ch", 32'(evt_ch), 32'(first_pending(m_pend, m_ptr)));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hits;
        int hit_at;
        // Inputs high through reset: nothing may be reported after release.
        rst_n = 1'b0; in_sig = 4'hF; mode = 8'h55; cnt_clr = '0; evt_ready = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(8);
        chk("prime_rdy", 32'(posReady), 32'h0);
        chk("prime_cnt", 32'(edge_cnt), 32'h0);
        chk("prime_valid", 32'(evt_valid), 32'h0);

        // Single rising edge on ch0: latency, count, event offer.
        rst_n = 1'b0; in_sig = '0;
        step(2);
        rst_n = 1'b1;
        step(3);
        in_sig[0] = 1'b1;
        step(LAT - 1);
        chk("lat_early", 32'(posReady), 32'h0);
        step(1);
        chk("lat_hit", 32'(posReady), 32'h1);
        chk("cnt0_one", 32'(edge_cnt[0 +: CW]), 32'd1);
        chk("evt_ch0", 32'(evt_ch), 32'd0);
        step(1);
        chk("lat_late", 32'(posReady), 32'h0);
        step(3);
        chk("evt_hold", 32'({evt_valid, evt_ch}), 32'h4);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("evt_taken", 32'(evt_valid), 32'h0);

        // ch1 both edges, ch0 neg only, ch3 masked; 10 full periods.
        mode = 8'h1E;
        for (int t = 0; t < 20; t++) begin
            in_sig[0] = ~in_sig[0];
            in_sig[1] = ~in_sig[1];
            in_sig[3] = ~in_sig[3];
            step(2);
        end
        step(LAT + 1);
        chk("cnt1_both", 32'(edge_cnt[1*CW +: CW]), 32'd20);
        chk("cnt1_model", 32'(m_cnt[1]), 32'd20);
        chk("cnt0_neg", 32'(edge_cnt[0 +: CW]), 32'd11);
        chk("cnt3_off", 32'(edge_cnt[3*CW +: CW]), 32'd0);
        chk("ovf1", 32'(ovf[1]), 32'd1);

        // ch2 saturation: 40 rising edges.
        for (int t = 0; t < 40; t++) begin
            in_sig[2] = 1'b1;
            step(2);
            in_sig[2] = 1'b0;
            step(2);
        end
        step(LAT + 1);
        chk("cnt2_sat", 32'(edge_cnt[2*CW +: CW]), 32'd31);
        chk("cnt2_model", 32'(m_cnt[2]), 32'd31);

        // Clear in the same cycle as an edge on ch2.
        in_sig[2] = 1'b1;
        step(LAT - 1);
        cnt_clr[2] = 1'b1;
        step(1);
        cnt_clr = '0;
        chk("clr_rdy", 32'(posReady[2]), 32'd1);
        chk("clr_cnt", 32'(edge_cnt[2*CW +: CW]), 32'd0);
        chk("clr_pend", 32'(m_pend[2]), 32'd1);

        // Mid-operation reset discards everything.
        rst_n = 1'b0; in_sig = '0; mode = 8'h55;
        step(2);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_cnt", 32'(edge_cnt), 32'h0);
        rst_n = 1'b1;
        step(3);

        // Pending on 0,1,3; overflow on ch3; then grants in RR order.
        in_sig = 4'b1011;
        step(LAT);
        chk("rr_first", 32'(evt_ch), 32'd0);
        in_sig[3] = 1'b0;
        step(2);
        in_sig[3] = 1'b1;
        step(LAT + 1);
        chk("ovf3_set", 32'(ovf[3]), 32'd1);
        cnt_clr[3] = 1'b1;
        step(1);
        cnt_clr = '0;
        chk("ovf3_clr", 32'(ovf[3]), 32'd0);
        evt_ready = 1'b1;
        chk("rr_g0", 32'(evt_ch), 32'd0);
        step(1);
        chk("rr_g1", 32'(evt_ch), 32'd1);
        step(1);
        chk("rr_g3", 32'(evt_ch), 32'd3);
        step(1);
        chk("rr_empty", 32'(evt_valid), 32'd0);
        in_sig = '0;
        step(LAT + 2);
        in_sig = 4'b0101;
        step(LAT);
        chk("rr_wrap0", 32'(evt_ch), 32'd0);
        step(1);
        chk("rr_wrap2", 32'(evt_ch), 32'd2);
        step(1);
        chk("rr_wrap_empty", 32'(evt_valid), 32'd0);

        // One-cycle pulse on ch0.
        in_sig = '0;
        step(4);
        hits = 0;
        in_sig[0] = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            step(1);
            if (i == 1) in_sig[0] = 1'b0;
            if (posReady[0]) hits++;
        end
        chk("pulse1_hits", 32'(hits), 32'(1 - FILT));

        // Two-cycle pulse on ch0.
        step(2);
        hits = 0;
        hit_at = -1;
        in_sig[0] = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            step(1);
            if (i == 2) in_sig[0] = 1'b0;
            if (posReady[0]) begin
                hits++;
                if (hit_at < 0) hit_at = i;
            end
        end
        chk("pulse2_hits", 32'(hits), 32'd1);
        chk("pulse2_lat", 32'(hit_at), 32'(LAT));

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
